// File: rtl/pll_refclk_sequencer.sv
// rtl/pll_refclk_sequencer.sv - ordered refclk switchover, reset and lock sequencer for the 2x pixel PLL
module pll_refclk_sequencer #(
    parameter int SWITCH_PULSE_CYC = 4,
    parameter int SWITCH_TIMEOUT   = 2700,
    parameter int ARESET_CYC       = 27,
    parameter int LOCK_STABLE_CYC  = 270,
    parameter int LOCK_TIMEOUT     = 270000,
    parameter int MAX_RETRY        = 3,
    parameter int WARN_CYC         = 16777215
) (
    input  logic       clk27,
    input  logic       clk_reset_n,
    input  logic       sel_i,
    input  logic       reconfig_busy_i,
    input  logic       activeclock_i,
    input  logic       locked_i,
    output logic       pll_clkswitch_o,
    output logic       pll_areset_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fail_o,
    output logic       lock_lost_o,
    output logic [2:0] state_o,
    output logic [2:0] retry_o
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int WW = $clog2(WARN_CYC + 1);

    typedef enum logic [2:0] {
        ST_ARST      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_LOCKED    = 3'd2,
        ST_SWITCH    = 3'd3,
        ST_WAIT_ACT  = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_sync_q, sel_sync_d;
    logic [1:0]      act_sync_q, act_sync_d;
    logic [1:0]      lck_sync_q, lck_sync_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic [WW-1:0]   warn_q, warn_d;
    logic [2:0]      retry_q, retry_d;
    logic            sel_prev_q, sel_prev_d;
    logic            clkswitch_q, clkswitch_d;
    logic            areset_q, areset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;
    logic            sel_s, act_s, lck_s;
    logic            timer_run;
    logic            warn_load;
    logic [2:0]      retry_inc;
    logic            retry_last;

    assign sel_s = sel_sync_q[1];
    assign act_s = act_sync_q[1];
    assign lck_s = lck_sync_q[1];

    assign retry_inc  = (retry_q == 3'(MAX_RETRY)) ? retry_q : retry_q + 3'd1;
    assign retry_last = (retry_q >= 3'(MAX_RETRY - 1));

    // state register; reset parks the PLL in areset immediately
    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            state_q <= ST_ARST;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state decisions, retry accounting and warn reload requests
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        timer_run = 1'b1;
        warn_load = 1'b0;
        case (state_q)
            ST_ARST: begin
                if (timer_q == TW'(ARESET_CYC - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lck_s && (stab_q == SW'(LOCK_STABLE_CYC - 1))) begin
                    state_d = ST_LOCKED;
                    retry_d = 3'd0;
                end else if (sel_s != act_s) begin
                    state_d = ST_SWITCH;
                end else if (reconfig_busy_i) begin
                    timer_run = 1'b0;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = retry_last ? ST_FAIL : ST_ARST;
                end
            end
            ST_LOCKED: begin
                // a scan in progress makes activeclock/locked meaningless
                if (!reconfig_busy_i) begin
                    if (sel_s != act_s) begin
                        state_d = ST_SWITCH;
                    end else if (!lck_s) begin
                        state_d   = ST_WAIT_LOCK;
                        warn_load = 1'b1;
                    end
                end
            end
            ST_SWITCH: begin
                if (timer_q == TW'(SWITCH_PULSE_CYC - 1)) state_d = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (act_s == sel_s) begin
                    state_d = ST_ARST;
                end else if (timer_q == TW'(SWITCH_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = retry_last ? ST_FAIL : ST_SWITCH;
                end
            end
            ST_FAIL: begin
                if (sel_s != sel_prev_q) begin
                    retry_d = 3'd0;
                    state_d = (sel_s != act_s) ? ST_SWITCH : ST_ARST;
                end
            end
            default: state_d = ST_ARST;
        endcase
        if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) warn_load = 1'b1;
    end

    // registered outputs decoded from the upcoming state so they move with it
    always_comb begin
        clkswitch_d = (state_d == ST_SWITCH);
        areset_d    = (state_d == ST_ARST);
        busy_d      = !((state_d == ST_LOCKED) || (state_d == ST_FAIL));
        done_d      = (state_d == ST_LOCKED) && (state_q != ST_LOCKED);
        fail_d      = (state_d == ST_FAIL);
    end

    // synchronizers, shared timer, lock stability and warn counters
    always_comb begin
        sel_sync_d = {sel_sync_q[0], sel_i};
        act_sync_d = {act_sync_q[0], activeclock_i};
        lck_sync_d = {lck_sync_q[0], locked_i};
        sel_prev_d = sel_s;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_run && (timer_q != {TW{1'b1}})) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
        if ((state_q == ST_WAIT_LOCK) && lck_s) begin
            stab_d = (stab_q == {SW{1'b1}}) ? stab_q : stab_q + 1'b1;
        end else begin
            stab_d = '0;
        end
        if (warn_load) begin
            warn_d = WW'(WARN_CYC);
        end else if (warn_q != '0) begin
            warn_d = warn_q - 1'b1;
        end else begin
            warn_d = warn_q;
        end
    end

    // datapath and output registers
    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            sel_sync_q  <= 2'b00;
            act_sync_q  <= 2'b00;
            lck_sync_q  <= 2'b00;
            sel_prev_q  <= 1'b0;
            timer_q     <= '0;
            stab_q      <= '0;
            warn_q      <= '0;
            retry_q     <= 3'd0;
            clkswitch_q <= 1'b0;
            areset_q    <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sel_sync_q  <= sel_sync_d;
            act_sync_q  <= act_sync_d;
            lck_sync_q  <= lck_sync_d;
            sel_prev_q  <= sel_prev_d;
            timer_q     <= timer_d;
            stab_q      <= stab_d;
            warn_q      <= warn_d;
            retry_q     <= retry_d;
            clkswitch_q <= clkswitch_d;
            areset_q    <= areset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_clkswitch_o = clkswitch_q;
    assign pll_areset_o    = areset_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign fail_o          = fail_q;
    assign lock_lost_o     = (warn_q != '0);
    assign state_o         = state_q;
    assign retry_o         = retry_q;
endmodule
